// File: rtl/traffic_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_phase_sequencer
//  Brief    : Six-phase two-direction intersection sequencer with a 1 Hz
//             countdown, flashing-yellow maintenance mode and hold input.
//             Optional pedestrian shortening of green: PED_REQUEST_EN.
//  Revision : 1.0  initial release
// ============================================================================
module traffic_phase_sequencer #(
    parameter int CW       = 6,
    parameter int T_GREEN  = 10,
    parameter int T_YELLOW = 5,
    parameter int T_ALLRED = 2,
    parameter int PED_MIN  = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pulse,
    input  logic          mode,
    input  logic          hold,
`ifdef PED_REQUEST_EN
    input  logic          ped_req,
`endif
    output logic [2:0]    ns_light,
    output logic [2:0]    ew_light,
    output logic [2:0]    phase,
    output logic [CW-1:0] sec_count,
    output logic          timeout
);

    localparam logic [2:0] c_ns_g   = 3'd0;
    localparam logic [2:0] c_ns_y   = 3'd1;
    localparam logic [2:0] c_ar1    = 3'd2;
    localparam logic [2:0] c_ew_g   = 3'd3;
    localparam logic [2:0] c_ew_y   = 3'd4;
    localparam logic [2:0] c_ar2    = 3'd5;
    localparam logic [2:0] c_unused = 3'd6;
    localparam logic [2:0] c_flash  = 3'd7;

    localparam logic [2:0] c_red    = 3'b100;
    localparam logic [2:0] c_yellow = 3'b010;
    localparam logic [2:0] c_green  = 3'b001;
    localparam logic [2:0] c_dark   = 3'b000;

    localparam logic [CW-1:0] c_t_green  = CW'(T_GREEN);
    localparam logic [CW-1:0] c_t_yellow = CW'(T_YELLOW);
    localparam logic [CW-1:0] c_t_allred = CW'(T_ALLRED);
    localparam logic [CW-1:0] c_one      = CW'(1);
    localparam logic [CW-1:0] c_zero     = '0;

    if (T_GREEN < 1 || T_GREEN > (2**CW) - 1) begin : g_bad_green
        $error("T_GREEN must lie in 1..2^CW-1");
    end
    if (T_YELLOW < 1 || T_YELLOW > (2**CW) - 1) begin : g_bad_yellow
        $error("T_YELLOW must lie in 1..2^CW-1");
    end
    if (T_ALLRED < 1 || T_ALLRED > (2**CW) - 1) begin : g_bad_allred
        $error("T_ALLRED must lie in 1..2^CW-1");
    end

    logic [2:0]    r_phase;
    logic [CW-1:0] r_sec;
    logic          r_timeout;
    logic [2:0]    r_ns;
    logic [2:0]    r_ew;

    logic [2:0]    w_phase_nx;
    logic [2:0]    w_phase_adv;
    logic [CW-1:0] w_sec_nx;
    logic          w_timeout_nx;
    logic [2:0]    w_ns_nx;
    logic [2:0]    w_ew_nx;
    logic          w_ped_load;

    // Lamp pattern {ns, ew} for each sequencing phase.
    function automatic logic [5:0] f_lamps(input logic [2:0] ph);
        case (ph)
            c_ns_g:  f_lamps = {c_green,  c_red};
            c_ns_y:  f_lamps = {c_yellow, c_red};
            c_ew_g:  f_lamps = {c_red,    c_green};
            c_ew_y:  f_lamps = {c_red,    c_yellow};
            default: f_lamps = {c_red,    c_red};
        endcase
    endfunction

    // Duration loaded on entry to a phase.
    function automatic logic [CW-1:0] f_load(input logic [2:0] ph);
        case (ph)
            c_ns_g, c_ew_g: f_load = c_t_green;
            c_ns_y, c_ew_y: f_load = c_t_yellow;
            default:        f_load = c_t_allred;
        endcase
    endfunction

`ifdef PED_REQUEST_EN
    localparam logic [CW-1:0] c_ped_min = CW'(PED_MIN);

    if (PED_MIN >= T_GREEN) begin : g_bad_ped
        $error("PED_MIN must be smaller than T_GREEN");
    end

    logic r_ped_used;

    assign w_ped_load = mode && !hold && ped_req && !r_ped_used &&
                        (r_phase == c_ns_g || r_phase == c_ew_g) &&
                        (r_sec > c_ped_min);

    // One shortening per green; any phase change re-arms it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ped_used <= 1'b0;
        end else if (w_phase_nx != r_phase) begin
            r_ped_used <= 1'b0;
        end else if (w_ped_load) begin
            r_ped_used <= 1'b1;
        end
    end
`else
    assign w_ped_load = 1'b0;
`endif

    assign w_phase_adv = (r_phase == c_ar2) ? c_ns_g : r_phase + 3'd1;

    always_comb begin
        w_phase_nx   = r_phase;
        w_sec_nx     = r_sec;
        w_timeout_nx = 1'b0;
        w_ns_nx      = r_ns;
        w_ew_nx      = r_ew;
        if (!mode) begin
            if (r_phase != c_flash) begin
                w_phase_nx = c_flash;
                w_sec_nx   = c_zero;
                w_ns_nx    = c_yellow;
                w_ew_nx    = c_yellow;
            end else if (pulse) begin
                w_ns_nx = (r_ns == c_yellow) ? c_dark : c_yellow;
                w_ew_nx = (r_ns == c_yellow) ? c_dark : c_yellow;
            end
        end else if (r_phase == c_flash || r_phase == c_unused) begin
            // Leaving maintenance (or an illegal code) always goes through clearance.
            w_phase_nx         = c_ar2;
            w_sec_nx           = c_t_allred;
            {w_ns_nx, w_ew_nx} = f_lamps(c_ar2);
        end else if (!hold) begin
            if (w_ped_load) begin
`ifdef PED_REQUEST_EN
                w_sec_nx = c_ped_min;
`endif
            end else if (pulse) begin
                if (r_sec > c_one) begin
                    w_sec_nx = r_sec - c_one;
                end else begin
                    w_phase_nx         = w_phase_adv;
                    w_sec_nx           = f_load(w_phase_adv);
                    w_timeout_nx       = 1'b1;
                    {w_ns_nx, w_ew_nx} = f_lamps(w_phase_adv);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase   <= c_ns_g;
            r_sec     <= c_t_green;
            r_timeout <= 1'b0;
            r_ns      <= c_green;
            r_ew      <= c_red;
        end else begin
            r_phase   <= w_phase_nx;
            r_sec     <= w_sec_nx;
            r_timeout <= w_timeout_nx;
            r_ns      <= w_ns_nx;
            r_ew      <= w_ew_nx;
        end
    end

    assign phase     = r_phase;
    assign sec_count = r_sec;
    assign timeout   = r_timeout;
    assign ns_light  = r_ns;
    assign ew_light  = r_ew;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_phase_sequencer
//  Brief    : Self-checking bench: table-driven reference model compared
//             every cycle, plus directed literal checks (PED_REQUEST_EN aware).
//  Revision : 1.0  initial release
// ============================================================================
module tb_traffic_phase_sequencer;

    localparam int C_TG = 10;
    localparam int C_TY = 5;
    localparam int C_TA = 2;
    localparam int C_PM = 3;

    logic       clk = 1'b0;
    logic       rst_n, pulse, mode, hold, ped_req;
    logic [2:0] ns_light, ew_light, phase;
    logic [5:0] sec_count;
    logic       timeout;

    logic [2:0] ns4, ew4, phase4;
    logic [3:0] sec4;
    logic       to4;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    traffic_phase_sequencer #(.CW(6), .T_GREEN(C_TG), .T_YELLOW(C_TY),
                              .T_ALLRED(C_TA), .PED_MIN(C_PM)) u_dut (
        .clk(clk), .rst_n(rst_n), .pulse(pulse), .mode(mode), .hold(hold),
`ifdef PED_REQUEST_EN
        .ped_req(ped_req),
`endif
        .ns_light(ns_light), .ew_light(ew_light), .phase(phase),
        .sec_count(sec_count), .timeout(timeout)
    );

    // Narrow-counter build: green of 15 must fit in 4 bits without wrapping.
    traffic_phase_sequencer #(.CW(4), .T_GREEN(15), .T_YELLOW(5),
                              .T_ALLRED(2), .PED_MIN(3)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .pulse(pulse), .mode(1'b1), .hold(1'b0),
`ifdef PED_REQUEST_EN
        .ped_req(1'b0),
`endif
        .ns_light(ns4), .ew_light(ew4), .phase(phase4),
        .sec_count(sec4), .timeout(to4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int dur_of(input int ph);
        int t[6] = '{C_TG, C_TY, C_TA, C_TG, C_TY, C_TA};
        return t[ph];
    endfunction

    function automatic logic [5:0] lamps_of(input int ph);
        logic [5:0] t[6] = '{6'b001_100, 6'b010_100, 6'b100_100,
                             6'b100_001, 6'b100_010, 6'b100_100};
        return t[ph];
    endfunction

    int         m_ph, m_sec, m_old;
    logic       m_to, m_used;
    logic [2:0] m_ns, m_ew;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b1;
            m_ph = 0; m_sec = C_TG; m_to = 1'b0;
            m_ns = 3'b001; m_ew = 3'b100; m_used = 1'b0;
        end else if (m_valid) begin
            m_old = m_ph;
            m_to  = 1'b0;
            if (!mode) begin
                if (m_ph != 7) begin
                    m_ph = 7; m_sec = 0; m_ns = 3'b010; m_ew = 3'b010;
                end else if (pulse) begin
                    m_ns = (m_ns == 3'b010) ? 3'b000 : 3'b010;
                    m_ew = m_ns;
                end
            end else if (m_ph == 7) begin
                m_ph = 5; m_sec = C_TA; {m_ns, m_ew} = lamps_of(5);
            end else if (!hold) begin
`ifdef PED_REQUEST_EN
                if (ped_req && !m_used && (m_ph == 0 || m_ph == 3) && m_sec > C_PM) begin
                    m_sec = C_PM; m_used = 1'b1;
                end else
`endif
                if (pulse) begin
                    if (m_sec > 1) m_sec--;
                    else begin
                        m_ph = (m_ph + 1) % 6;
                        m_sec = dur_of(m_ph);
                        m_to = 1'b1;
                        {m_ns, m_ew} = lamps_of(m_ph);
                    end
                end
            end
            if (m_ph != m_old) m_used = 1'b0;
        end
        #1;
        if (m_valid) begin
            chk("model phase", phase, m_ph);
            chk("model sec_count", sec_count, m_sec);
            chk("model timeout", timeout, m_to);
            chk("model ns_light", ns_light, m_ns);
            chk("model ew_light", ew_light, m_ew);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input logic p);
        pulse = p;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b1; hold = 1'b0; pulse = 1'b0; ped_req = 1'b0;
        @(negedge clk);
        cyc(0); cyc(0);
        chk("reset phase", phase, 0);
        chk("reset sec", sec_count, 10);
        chk("reset timeout", timeout, 0);
        chk("reset ns", ns_light, 3'b001);
        chk("reset ew", ew_light, 3'b100);
        chk("reset cw4 sec", sec4, 15);
        rst_n = 1'b1;

        for (int k = 1; k <= 34; k++) begin
            cyc(1);
            if (k == 9) begin
                chk("ns_g last sec", sec_count, 1);
                chk("ns_g last phase", phase, 0);
                chk("ns_g timeout low", timeout, 0);
            end
            if (k == 10) begin
                chk("ns_y phase", phase, 1);
                chk("ns_y sec", sec_count, 5);
                chk("ns_y timeout", timeout, 1);
                chk("ns_y lamps", {ns_light, ew_light}, 6'b010_100);
                cyc(0);
                chk("timeout one clk", timeout, 0);
            end
            if (k == 14) chk("cw4 sec 1", sec4, 1);
            if (k == 15) begin
                chk("cw4 phase", phase4, 1);
                chk("cw4 sec yellow", sec4, 5);
            end
            if (k == 17) begin
                chk("ew_g phase", phase, 3);
                chk("ew_g lamps", {ns_light, ew_light}, 6'b100_001);
            end
        end
        chk("cycle back phase", phase, 0);
        chk("cycle back sec", sec_count, 10);
        chk("cycle back timeout", timeout, 1);

        repeat (3) cyc(1);
        chk("pre-hold sec", sec_count, 7);
        hold = 1'b1;
        repeat (20) cyc(1);
        chk("hold sec", sec_count, 7);
        chk("hold phase", phase, 0);
        chk("hold lamps", {ns_light, ew_light}, 6'b001_100);
        hold = 1'b0;
        cyc(0);
        chk("release no pulse", sec_count, 7);
        cyc(1);
        chk("release pulse", sec_count, 6);

        repeat (25) cyc(1);
        chk("ew_y phase", phase, 4);
        chk("ew_y sec", sec_count, 3);
        mode = 1'b0;
        cyc(0);
        chk("flash phase", phase, 7);
        chk("flash sec", sec_count, 0);
        chk("flash lamps on", {ns_light, ew_light}, 6'b010_010);
        chk("flash timeout", timeout, 0);
        cyc(1);
        chk("flash lamps off", {ns_light, ew_light}, 6'b000_000);
        cyc(1);
        chk("flash lamps on2", {ns_light, ew_light}, 6'b010_010);
        hold = 1'b1;
        cyc(1);
        chk("flash ignores hold", {ns_light, ew_light}, 6'b000_000);
        hold = 1'b0;
        mode = 1'b1;
        cyc(0);
        chk("exit phase", phase, 5);
        chk("exit sec", sec_count, 2);
        chk("exit lamps", {ns_light, ew_light}, 6'b100_100);
        cyc(1); cyc(1);
        chk("after flash phase", phase, 0);
        chk("after flash sec", sec_count, 10);

        repeat (23) cyc(1);
        chk("pre-reset phase", phase, 3);
        chk("pre-reset sec", sec_count, 4);
        rst_n = 1'b0;
        cyc(1);
        chk("mid reset phase", phase, 0);
        chk("mid reset sec", sec_count, 10);
        chk("mid reset timeout", timeout, 0);
        chk("mid reset lamps", {ns_light, ew_light}, 6'b001_100);
        rst_n = 1'b1;

`ifdef PED_REQUEST_EN
        repeat (2) cyc(1);
        chk("pre-ped sec", sec_count, 8);
        ped_req = 1'b1;
        cyc(0);
        chk("ped load", sec_count, 3);
        cyc(1);
        chk("ped repeat ignored", sec_count, 2);
        cyc(0);
        chk("ped at 2 ignored", sec_count, 2);
        ped_req = 1'b0;
`endif
        cyc(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
